// File: rtl/unary_dot_accumulator.sv
// Unary dot-product decoder: integrates per-cycle adder-tree pulse counts into a binary sum.
// Result registered one cycle after the cycle in which every product block reports done.
// Result held on out_valid until out_ready; starts arriving while busy or held are dropped and flagged.
// Optional build macro UDA_CYCLE_COUNT_EN adds a cycle_count output captured with the result.
module unary_dot_accumulator #(
    parameter int WIDTH     = 4,
    parameter int NUM_PRODS = 16,
    parameter int TREE_W    = $clog2(NUM_PRODS + 1),
    parameter int ACC_W     = 2 * WIDTH + $clog2(NUM_PRODS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [TREE_W-1:0]    pulse_sum,
    input  logic [NUM_PRODS-1:0] done_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_data,
    output logic                 busy,
`ifdef UDA_CYCLE_COUNT_EN
    output logic [ACC_W:0]       cycle_count,
`endif
    output logic                 start_drop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic             all_done;
`ifdef UDA_CYCLE_COUNT_EN
    logic [ACC_W:0]   cnt;
    logic [ACC_W:0]   cnt_next;
`endif

    // Running sum including this cycle's pulses, so the final cycle's pulses land in the result.
    always_comb begin
        all_done = &done_vec;
        acc_next = acc + ACC_W'(pulse_sum);
`ifdef UDA_CYCLE_COUNT_EN
        cnt_next = cnt + (ACC_W + 1)'(1);
`endif
    end

    // Control FSM with registered outputs; start_drop defaults low so it is a single-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            start_drop <= 1'b0;
`ifdef UDA_CYCLE_COUNT_EN
            cnt         <= '0;
            cycle_count <= '0;
`endif
        end else begin
            start_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCUM;
                        acc   <= '0;
                        busy  <= 1'b1;
`ifdef UDA_CYCLE_COUNT_EN
                        cnt   <= '0;
`endif
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
`ifdef UDA_CYCLE_COUNT_EN
                    cnt <= cnt_next;
`endif
                    if (start) begin
                        start_drop <= 1'b1;
                    end
                    if (all_done) begin
                        state     <= VALID;
                        out_data  <= acc_next;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
`ifdef UDA_CYCLE_COUNT_EN
                        cycle_count <= cnt_next;
`endif
                    end
                end
                VALID: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            // Handshake and new window in the same cycle: no bubble.
                            state <= ACCUM;
                            acc   <= '0;
                            busy  <= 1'b1;
`ifdef UDA_CYCLE_COUNT_EN
                            cnt   <= '0;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else if (start) begin
                        start_drop <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unary_dot_accumulator.sv
// Directed bench for unary_dot_accumulator: per-cycle vector table plus hand-written long/reset sequences.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
// Result line summarises the error and check counts.
module tb_unary_dot_accumulator;

    localparam int WIDTH     = 4;
    localparam int NUM_PRODS = 16;
    localparam int TREE_W    = $clog2(NUM_PRODS + 1);
    localparam int ACC_W     = 2 * WIDTH + $clog2(NUM_PRODS);

    logic                 clk;
    logic                 reset_n;
    logic                 start;
    logic [TREE_W-1:0]    pulse_sum;
    logic [NUM_PRODS-1:0] done_vec;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_data;
    logic                 busy;
    logic                 start_drop;
`ifdef UDA_CYCLE_COUNT_EN
    logic [ACC_W:0]       cycle_count;
`endif

    int checks = 0;
    int errors = 0;

    unary_dot_accumulator #(
        .WIDTH(WIDTH),
        .NUM_PRODS(NUM_PRODS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .pulse_sum(pulse_sum),
        .done_vec(done_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy),
`ifdef UDA_CYCLE_COUNT_EN
        .cycle_count(cycle_count),
`endif
        .start_drop(start_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          reps;
        logic        start;
        logic [4:0]  pulse;
        logic [15:0] done;
        logic        ready;
        logic        exp_valid;
        logic [11:0] exp_data;
        logic        exp_busy;
        logic        exp_drop;
        logic [12:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int reps, logic st, logic [4:0] p, logic [15:0] d, logic rdy,
                                logic ev, logic [11:0] ed, logic eb, logic edr, logic [12:0] ec);
        vec_t v;
        v.reps = reps; v.start = st; v.pulse = p; v.done = d; v.ready = rdy;
        v.exp_valid = ev; v.exp_data = ed; v.exp_busy = eb; v.exp_drop = edr; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [4:0] p, input logic [15:0] d, input logic rdy);
        start     = st;
        pulse_sum = p;
        done_vec  = d;
        out_ready = rdy;
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [11:0] ed,
                              input logic eb, input logic edr);
        check({tag, ".out_valid"},  32'(out_valid),  32'(ev));
        check({tag, ".out_data"},   32'(out_data),   32'(ed));
        check({tag, ".busy"},       32'(busy),       32'(eb));
        check({tag, ".start_drop"}, 32'(start_drop), 32'(edr));
    endtask

    initial begin
        bit never_valid;

        // start pulse ps done rdy | valid data busy drop cnt
        // Single pulse: 16 then done -> 16 after 2 ACCUM cycles
        vecs.push_back(mk(1,  1'b1, 5'd0,  16'h0000, 1'b0, 1'b0, 12'd0,  1'b1, 1'b0, 13'd0));
        vecs.push_back(mk(1,  1'b0, 5'd16, 16'h0000, 1'b0, 1'b0, 12'd0,  1'b1, 1'b0, 13'd0));
        vecs.push_back(mk(1,  1'b0, 5'd0,  16'hFFFF, 1'b0, 1'b1, 12'd16, 1'b0, 1'b0, 13'd2));
        vecs.push_back(mk(1,  1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 12'd16, 1'b0, 1'b0, 13'd0));
        // Partial done: 10 cycles of 1 with one block not done, then 2 with all done -> 12
        vecs.push_back(mk(1,  1'b1, 5'd0,  16'h0000, 1'b0, 1'b0, 12'd16, 1'b1, 1'b0, 13'd0));
        vecs.push_back(mk(10, 1'b0, 5'd1,  16'hFFFE, 1'b0, 1'b0, 12'd16, 1'b1, 1'b0, 13'd0));
        vecs.push_back(mk(1,  1'b0, 5'd2,  16'hFFFF, 1'b0, 1'b1, 12'd12, 1'b0, 1'b0, 13'd11));
        vecs.push_back(mk(1,  1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 12'd12, 1'b0, 1'b0, 13'd0));
        // Build 42 = 16 + 16 + 10
        vecs.push_back(mk(1,  1'b1, 5'd0,  16'h0000, 1'b0, 1'b0, 12'd12, 1'b1, 1'b0, 13'd0));
        vecs.push_back(mk(2,  1'b0, 5'd16, 16'h0000, 1'b0, 1'b0, 12'd12, 1'b1, 1'b0, 13'd0));
        vecs.push_back(mk(1,  1'b0, 5'd10, 16'hFFFF, 1'b0, 1'b1, 12'd42, 1'b0, 1'b0, 13'd3));
        // Backpressure 5 cycles, start dropped in cycle 2, pulses ignored while held
        vecs.push_back(mk(1,  1'b0, 5'd5,  16'hFFFF, 1'b0, 1'b1, 12'd42, 1'b0, 1'b0, 13'd3));
        vecs.push_back(mk(1,  1'b1, 5'd5,  16'hFFFF, 1'b0, 1'b1, 12'd42, 1'b0, 1'b1, 13'd3));
        vecs.push_back(mk(3,  1'b0, 5'd5,  16'hFFFF, 1'b0, 1'b1, 12'd42, 1'b0, 1'b0, 13'd3));
        // Back-to-back: handshake + start together; start in ACCUM dropped; new sum 3+4=7
        vecs.push_back(mk(1,  1'b1, 5'd0,  16'h0000, 1'b1, 1'b0, 12'd42, 1'b1, 1'b0, 13'd0));
        vecs.push_back(mk(1,  1'b1, 5'd3,  16'h0000, 1'b0, 1'b0, 12'd42, 1'b1, 1'b1, 13'd0));
        vecs.push_back(mk(1,  1'b0, 5'd4,  16'hFFFF, 1'b0, 1'b1, 12'd7,  1'b0, 1'b0, 13'd2));
        vecs.push_back(mk(1,  1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 12'd7,  1'b0, 1'b0, 13'd0));
        // IDLE ignores pulses and done flags
        vecs.push_back(mk(1,  1'b0, 5'd9,  16'hFFFF, 1'b0, 1'b0, 12'd7,  1'b0, 1'b0, 13'd0));

        reset_n = 1'b0;
        drive(1'b0, 5'd0, 16'h0000, 1'b0);
        tick();
        tick();
        check_outs("reset", 1'b0, 12'd0, 1'b0, 1'b0);
`ifdef UDA_CYCLE_COUNT_EN
        check("reset.cycle_count", 32'(cycle_count), 32'd0);
`endif
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(vecs[i].start, vecs[i].pulse, vecs[i].done, vecs[i].ready);
                tick();
                check_outs($sformatf("vec%0d.%0d", i, r), vecs[i].exp_valid, vecs[i].exp_data,
                           vecs[i].exp_busy, vecs[i].exp_drop);
`ifdef UDA_CYCLE_COUNT_EN
                if (vecs[i].exp_valid)
                    check($sformatf("vec%0d.%0d.cycle_count", i, r), 32'(cycle_count), 32'(vecs[i].exp_cnt));
`endif
            end
        end

        // Max magnitude: 225 cycles of 16 then all done -> 3600
        drive(1'b1, 5'd0, 16'h0000, 1'b0);
        tick();
        never_valid = 1'b1;
        for (int c = 0; c < 225; c++) begin
            drive(1'b0, 5'd16, 16'h0000, 1'b0);
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b1) never_valid = 1'b0;
        end
        check("max.no_early_valid", 32'(never_valid), 32'd1);
        drive(1'b0, 5'd0, 16'hFFFF, 1'b0);
        tick();
        check_outs("max", 1'b1, 12'd3600, 1'b0, 1'b0);
`ifdef UDA_CYCLE_COUNT_EN
        check("max.cycle_count", 32'(cycle_count), 32'd226);
`endif
        drive(1'b0, 5'd0, 16'h0000, 1'b1);
        tick();
        check("max.accept", 32'(out_valid), 32'd0);

        // Reset mid-ACCUM after acc reaches 50
        drive(1'b1, 5'd0, 16'h0000, 1'b0);
        tick();
        drive(1'b0, 5'd25, 16'h0000, 1'b0);
        tick();
        tick();
        check("rst.busy_before", 32'(busy), 32'd1);
        drive(1'b0, 5'd0, 16'h0000, 1'b0);
        reset_n = 1'b0;
        #1;
        check_outs("rst.async", 1'b0, 12'd0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        drive(1'b1, 5'd0, 16'h0000, 1'b0);
        tick();
        check("rst.restart_busy", 32'(busy), 32'd1);
        drive(1'b0, 5'd5, 16'h0000, 1'b0);
        tick();
        drive(1'b0, 5'd6, 16'hFFFF, 1'b0);
        tick();
        check_outs("rst.fresh", 1'b1, 12'd11, 1'b0, 1'b0);
`ifdef UDA_CYCLE_COUNT_EN
        check("rst.fresh.cycle_count", 32'(cycle_count), 32'd2);
`endif
        drive(1'b0, 5'd0, 16'h0000, 1'b1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
